// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide sequencer
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic op_is_div(input op_t o);
        return o[1];
    endfunction

    function automatic logic op_is_signed(input op_t o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one combinational radix-2 step: shift-add multiply or restoring divide
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = {add_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            // Remainder stays below the divisor, so bit WIDTH of diff is a pure borrow flag.
            q_bit    = ~diff[WIDTH];
            acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO write-back
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q, b_q, operand;
    logic [2*WIDTH-1:0] acc, acc_core, prod_fix;
    logic [CW-1:0]      count;
    logic               neg_hi, neg_lo;
    logic               q_bit, is_div, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign is_div   = op_is_div(op_q);
    assign sa       = op_is_signed(op_q) & a_q[WIDTH-1];
    assign sb       = op_is_signed(op_q) & b_q[WIDTH-1];
    assign abs_a    = sa ? -a_q : a_q;
    assign abs_b    = sb ? -b_q : b_q;
    assign prod_fix = neg_hi ? -acc : acc;

    assign busy  = (state != S_IDLE);
    assign hi_we = done;
    assign lo_we = done;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .acc      (acc),
        .operand  (operand),
        .is_div   (is_div),
        .acc_next (acc_core),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_q     <= OP_MULT;
            a_q      <= '0;
            b_q      <= '0;
            operand  <= '0;
            acc      <= '0;
            count    <= '0;
            neg_hi   <= 1'b0;
            neg_lo   <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (start && !abort) begin
                        op_q  <= op_t'(op);
                        a_q   <= a;
                        b_q   <= b;
                        state <= S_PREP;
                    end
                    S_PREP: begin
                        // Iterate on magnitudes; the sign is restored in FIX.
                        operand <= is_div ? abs_b : abs_a;
                        acc     <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                        neg_lo  <= sa ^ sb;
                        neg_hi  <= is_div ? sa : (sa ^ sb);
                        count   <= CW'(WIDTH);
                        state   <= S_RUN;
                    end
                    S_RUN: begin
                        acc   <= acc_core | {{(2*WIDTH-1){1'b0}}, q_bit};
                        count <= count - CW'(1);
                        if (count == CW'(1)) state <= S_FIX;
                    end
                    S_FIX: begin
                        if (is_div) begin
                            hi_wdata <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                            lo_wdata <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        end else begin
                            hi_wdata <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_wdata <= prod_fix[WIDTH-1:0];
                        end
                        done     <= 1'b1;
                        div_zero <= is_div && (b_q == '0);
                        state    <= S_DONE;
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer for the multi-cycle CPU. It accepts MULT/MULTU/DIV/DIVU requests from the CPU controller and runs a radix-2 shift-add or restoring-divide core for WIDTH iterations. It holds busy so the controller stalls, then delivers HI/LO write-back with a one-cycle done/write-enable pulse. It sits between the controller, the register-file read ports (operands) and the HI/LO registers.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk_in  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low; 0 clears all state.
start  in  1  request strobe; sampled only in IDLE.
op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
abort  in  1  exception cancel; kills the in-flight operation.
a  in  WIDTH  rs operand (multiplicand / dividend); sampled with start.
b  in  WIDTH  rt operand (multiplier / divisor); sampled with start.
busy  out  1  high from the cycle after start is accepted through the DONE cycle.
done  out  1  one-cycle pulse in DONE.
hi_we  out  1  equals done.
lo_we  out  1  equals done.
hi_wdata  out  WIDTH  mult: product[2W-1:W]; div: remainder.
lo_wdata  out  WIDTH  mult: product[W-1:0]; div: quotient.
div_zero  out  1  in DONE: divide op with b==0; otherwise 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy, done, hi_we, lo_we and div_zero are 0. hi_wdata/lo_wdata are 0. Iteration counter is 0.
- FSM states and transitions:
  - IDLE: start=1 latches op/a/b, then goes to PREP. start=0 stays.
  - PREP (1 cycle): signed ops take the absolute value of each operand and record sign flags. Mult sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa. Unsigned ops pass operands through. Counter loads WIDTH. Next state is RUN.
  - RUN (WIDTH cycles): one iteration per cycle, counter decrements. Leaves for FIX when the counter reaches 1.
    - Mult: add-shift on a 2W accumulator.
    - Div: restoring shift-subtract.
  - FIX (1 cycle): applies the two's-complement sign correction and registers the results onto hi_wdata/lo_wdata. Next state is DONE.
  - DONE (1 cycle): done=hi_we=lo_we=1, then IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+WIDTH+2 (35 cycles for W=32). busy is high in exactly those cycles.
- Output hold: hi_wdata/lo_wdata hold their last result until the next FIX.
- start while busy is ignored; no queueing. Start in the DONE cycle is also ignored. The controller re-issues after done.
- abort in any non-IDLE state: next edge returns to IDLE, with no done/we pulse and results unchanged. Abort in the same cycle as start (IDLE) wins, so the start is dropped. Abort in IDLE has no effect.
- Divide by zero takes no trap and gives the natural algorithm result.
  - Unsigned: quotient=all-ones, remainder=a.
  - Signed: sign fix is applied to those magnitudes.
  - div_zero=1 in DONE.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): quotient=0x80000000, remainder=0. No flag.
- Width rules:
  - The product is exact in 2W bits, signed or unsigned.
  - Absolute values are held in W unsigned bits, so |−2^(W−1)| is representable.
- reset deasserted mid-operation is covered by the asynchronous clear only; no partial results survive.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - FSM state encodings S_IDLE/S_PREP/S_RUN/S_FIX/S_DONE;
  - width constant WIDTH_DEF=32.
- One sub-module, muldiv_iter_core: the per-cycle datapath step. Inputs are the accumulator, the operand and the mode. Outputs are the next accumulator and partial quotient bit. It is purely combinational. Registers and the FSM stay in muldiv_seq.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002 -> after 35 cycles: done/hi_we/lo_we pulse one cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFE; busy high exactly 35 cycles.
- MULTU a=0xFFFFFFFF b=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE. Also MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (−7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100 b=7 -> LO=0x0000000E, HI=0x00000002. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=0x00000007, div_zero=1 for one cycle. DIV a=0xFFFFFFF9 b=0 -> LO=0x00000001, HI=0xFFFFFFF9, div_zero=1.
- Start MULT, pulse start with new operands at cycle 10, then abort at cycle 20 -> second start ignored; busy drops the cycle after abort; no done; HI/LO outputs equal their prior values.
- Pull reset low asynchronously mid-RUN -> busy/done/outputs 0 immediately (no clock edge). After release, a fresh DIVU 100/7 completes with correct results in 35 cycles.
